// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants, clear FSM encoding and cell index helper
package vga_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;
    localparam int H_TOTAL    = 800;
    localparam int V_TOTAL    = 525;
    localparam int CELL_SHIFT = 3;
    localparam int COLS       = H_ACTIVE >> CELL_SHIFT;
    localparam int ROWS       = V_ACTIVE >> CELL_SHIFT;
    localparam int NCELLS     = COLS * ROWS;
    localparam int AW         = 13;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // row*80 + col, with 80 built as 64+16 so no multiplier is inferred
    function automatic logic [AW-1:0] cell_index(input logic [9:0] x, input logic [9:0] y);
        logic [AW-1:0] row;
        logic [AW-1:0] col;
        row = AW'(y >> CELL_SHIFT);
        col = AW'(x >> CELL_SHIFT);
        return (row << 6) + (row << 4) + col;
    endfunction

endpackage

// File: rtl/vga_fb_scanout_if.sv
// rtl/vga_fb_scanout_if.sv - CPU-side cell access and clear control bundle
interface vga_fb_scanout_if;

    logic                 wr_en;
    logic [vga_pkg::AW-1:0] wr_addr;
    logic [2:0]           wr_data;
    logic                 rd_en;
    logic [vga_pkg::AW-1:0] rd_addr;
    logic [2:0]           rd_data;
    logic                 clear_req;
    logic                 busy;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, clear_req,
        input  rd_data, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, clear_req,
        output rd_data, busy
    );

endinterface

// File: rtl/vga_fb_ram.sv
// rtl/vga_fb_ram.sv - cell RAM, one write port, two registered read-first read ports
module vga_fb_ram
    import vga_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [2:0]    wdata_i,
    input  logic [AW-1:0] addr_a_i,
    output logic [2:0]    q_a_o,
    input  logic          en_b_i,
    input  logic [AW-1:0] addr_b_i,
    output logic [2:0]    q_b_o
);

    logic [2:0] mem_q [NCELLS];
    logic [2:0] q_a_q;
    logic [2:0] q_b_q;

    // Single write port; callers guarantee waddr_i is in range when we_i is set
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Scan port: free-running, addresses past the grid read as black
    always_ff @(posedge clk) begin
        q_a_q <= (addr_a_i < AW'(NCELLS)) ? mem_q[addr_a_i] : 3'b000;
    end

    // CPU port: holds when not enabled, out-of-range reads return 0
    always_ff @(posedge clk) begin
        if (reset) begin
            q_b_q <= 3'b000;
        end else if (en_b_i) begin
            q_b_q <= (addr_b_i < AW'(NCELLS)) ? mem_q[addr_b_i] : 3'b000;
        end
    end

    assign q_a_o = q_a_q;
    assign q_b_o = q_b_q;

endmodule

// File: rtl/vga_fb_scanout.sv
// rtl/vga_fb_scanout.sv - cell framebuffer scanout with frame tracking and clear sequencer
module vga_fb_scanout
    import vga_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         cx,
    input  logic [9:0]         cy,
    input  logic               hs_in,
    input  logic               vs_in,
    vga_fb_scanout_if.slave    cpu,
    output logic [2:0]         rgb,
    output logic               hs,
    output logic               vs,
    output logic               vblank,
    output logic               frame_start,
    output logic [15:0]        frame_cnt
);

    logic [AW-1:0] cell_d;
    logic          active_d;
    logic          zero_d;

    logic          active_q;
    logic          hs1_q;
    logic          vs1_q;
    logic          zero_q;
    logic [2:0]    rgb_q;
    logic          hs_q;
    logic          vs_q;
    logic          vblank_q;
    logic          frame_start_q;
    logic [15:0]   frame_cnt_q;

    clr_state_t    state_q;
    logic [AW-1:0] ptr_q;
    logic          busy_q;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [2:0]    ram_wdata;
    logic [2:0]    scan_q;
    logic [2:0]    cpu_rd_q;

    assign cell_d   = cell_index(cx, cy);
    assign active_d = (cx < 10'(H_ACTIVE)) && (cy < 10'(V_ACTIVE));
    assign zero_d   = (cx == 10'd0) && (cy == 10'd0);

    // The RAM address register doubles as the stage-1 cell register
    vga_fb_ram u_ram (
        .clk      (clk),
        .reset    (reset),
        .we_i     (ram_we),
        .waddr_i  (ram_waddr),
        .wdata_i  (ram_wdata),
        .addr_a_i (cell_d),
        .q_a_o    (scan_q),
        .en_b_i   (cpu.rd_en),
        .addr_b_i (cpu.rd_addr),
        .q_b_o    (cpu_rd_q)
    );

    // Write arbitration: the clear sequencer owns the port while busy
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = cpu.wr_addr;
        ram_wdata = cpu.wr_data;
        if (state_q == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = ptr_q;
            ram_wdata = 3'b000;
        end else if (cpu.wr_en && (cpu.wr_addr < AW'(NCELLS))) begin
            ram_we    = 1'b1;
        end
    end

    // Two-stage scan pipeline with matching sync delays, vblank and frame tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q      <= 1'b0;
            hs1_q         <= 1'b1;
            vs1_q         <= 1'b0;
            zero_q        <= 1'b0;
            rgb_q         <= 3'b000;
            hs_q          <= 1'b1;
            vs_q          <= 1'b0;
            vblank_q      <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 16'd0;
        end else begin
            active_q      <= active_d;
            hs1_q         <= hs_in;
            vs1_q         <= vs_in;
            zero_q        <= zero_d;
            rgb_q         <= active_q ? scan_q : 3'b000;
            hs_q          <= hs1_q;
            vs_q          <= vs1_q;
            vblank_q      <= (cy >= 10'(V_ACTIVE));
            // Edge-detected so a timing counter parked at (0,0) counts once
            frame_start_q <= zero_d && !zero_q;
            if (zero_d && !zero_q) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    // Clear sequencer: sweeps every cell once; requests while sweeping are ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu.clear_req) begin
                        state_q <= CLEAR;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (ptr_q == AW'(NCELLS - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        ptr_q   <= ptr_q + AW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rgb         = rgb_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign vblank      = vblank_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;
    assign cpu.busy    = busy_q;
    assign cpu.rd_data = cpu_rd_q;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb/tb_vga_fb_scanout.sv - self-checking bench for vga_fb_scanout
module tb_vga_fb_scanout;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  cx;
    logic [9:0]  cy;
    logic        hs_in;
    logic        vs_in;
    logic [2:0]  rgb;
    logic        hs;
    logic        vs;
    logic        vblank;
    logic        frame_start;
    logic [15:0] frame_cnt;

    vga_fb_scanout_if bus();

    vga_fb_scanout dut (
        .clk         (clk),
        .reset       (reset),
        .cx          (cx),
        .cy          (cy),
        .hs_in       (hs_in),
        .vs_in       (vs_in),
        .cpu         (bus),
        .rgb         (rgb),
        .hs          (hs),
        .vs          (vs),
        .vblank      (vblank),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         x;
        int         y;
        logic       h;
        logic       v;
        logic [2:0] exp_rgb;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] model [NCELLS];
    logic [2:0] last_rd;
    vec_t       vecs [$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] ref_pixel(input int x, input int y);
        if (x < 640 && y < 480) return model[(y / 8) * 80 + x / 8];
        return 3'b000;
    endfunction

    function automatic logic [2:0] ref_read(input int a);
        if (a < NCELLS) return model[a];
        return 3'b000;
    endfunction

    task automatic idle_bus;
        bus.wr_en     = 1'b0;
        bus.rd_en     = 1'b0;
        bus.clear_req = 1'b0;
    endtask

    task automatic cpu_write(input int a, input logic [2:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 13'(a);
        bus.wr_data = d;
        tick;
        bus.wr_en   = 1'b0;
        if (a < NCELLS) model[a] = d;
    endtask

    task automatic cpu_read_check(input string name, input int a);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 13'(a);
        last_rd     = ref_read(a);
        tick;
        bus.rd_en   = 1'b0;
        check(name, 32'(bus.rd_data), 32'(last_rd));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int bc;
        logic [2:0] prev_rgb;
        logic prev_hs, prev_vs, prev_zero;
        int exp_cnt, pulses;

        reset = 1'b1;
        cx = 10'd100; cy = 10'd490; hs_in = 1'b0; vs_in = 1'b1;
        bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
        idle_bus;
        last_rd = 3'b000;

        // Reset with the timing counter running and syncs at their non-idle level
        for (int i = 0; i < 3; i++) begin
            tick;
            cx = cx + 10'd1;
            check("reset_rgb", 32'(rgb), 32'd0);
            check("reset_hs", 32'(hs), 32'd1);
            check("reset_vs", 32'(vs), 32'd0);
            check("reset_vblank", 32'(vblank), 32'd0);
            check("reset_fcnt", 32'(frame_cnt), 32'd0);
            check("reset_busy", 32'(bus.busy), 32'd0);
            check("reset_rd", 32'(bus.rd_data), 32'd0);
        end
        reset = 1'b0; hs_in = 1'b1; vs_in = 1'b0; cx = 10'd700; cy = 10'd0;

        // Fill the grid with white
        for (int a = 0; a < NCELLS; a++) begin
            bus.wr_en = 1'b1; bus.wr_addr = 13'(a); bus.wr_data = 3'b111;
            tick;
            model[a] = 3'b111;
        end
        bus.wr_en = 1'b0;
        cpu_read_check("fill_first", 0);
        cpu_read_check("fill_last", NCELLS - 1);

        // Hardware clear with a dropped CPU write, a late read and a second request
        bus.clear_req = 1'b1;
        tick;
        bus.clear_req = 1'b0;
        check("busy_start", 32'(bus.busy), 32'd1);
        bc = 1;
        for (int g = 0; g < 6000 && bus.busy === 1'b1; g++) begin
            bus.wr_en = (bc == 100); bus.wr_addr = 13'd10; bus.wr_data = 3'b101;
            bus.clear_req = (bc == 200);
            bus.rd_en = (bc == 300); bus.rd_addr = 13'(NCELLS - 1);
            tick;
            if (bc == 300) begin
                last_rd = 3'b111;
                check("rd_during_clear", 32'(bus.rd_data), 32'd7);
            end
            if (bus.busy === 1'b1) bc++;
        end
        idle_bus;
        check("busy_cycles", 32'(bc), 32'(NCELLS));
        for (int a = 0; a < NCELLS; a++) model[a] = 3'b000;
        for (int a = 0; a < NCELLS; a++) cpu_read_check("cleared_cell", a);

        // Read and write of one address in the same cycle return the old value
        cpu_write(5, 3'b010);
        bus.rd_en = 1'b1; bus.rd_addr = 13'd5;
        bus.wr_en = 1'b1; bus.wr_addr = 13'd5; bus.wr_data = 3'b001;
        tick;
        idle_bus;
        model[5] = 3'b001;
        check("rd_write_conflict", 32'(bus.rd_data), 32'd2);
        tick;
        check("rd_hold", 32'(bus.rd_data), 32'd2);
        cpu_read_check("rd_after_conflict", 5);
        cpu_write(NCELLS, 3'b111);
        cpu_read_check("rd_out_of_range", NCELLS);
        cpu_read_check("rd_last_untouched", NCELLS - 1);

        // Scan vectors over known cells, borders and blanking
        cpu_write(81, 3'b101);
        cpu_write(0, 3'b111);
        cpu_write(79, 3'b011);
        cpu_write(4720, 3'b110);
        cpu_write(4799, 3'b010);
        vecs.push_back('{8, 8, 1'b1, 1'b0, 3'b101});
        vecs.push_back('{15, 8, 1'b1, 1'b0, 3'b101});
        vecs.push_back('{8, 15, 1'b1, 1'b0, 3'b101});
        vecs.push_back('{15, 15, 1'b1, 1'b0, 3'b101});
        vecs.push_back('{12, 11, 1'b1, 1'b0, 3'b101});
        vecs.push_back('{16, 8, 1'b1, 1'b0, 3'b000});
        vecs.push_back('{7, 8, 1'b1, 1'b0, 3'b000});
        vecs.push_back('{8, 16, 1'b1, 1'b0, 3'b000});
        vecs.push_back('{0, 0, 1'b1, 1'b0, 3'b111});
        vecs.push_back('{640, 0, 1'b1, 1'b0, 3'b000});
        vecs.push_back('{639, 0, 1'b1, 1'b0, 3'b011});
        vecs.push_back('{656, 0, 1'b0, 1'b0, 3'b000});
        vecs.push_back('{700, 0, 1'b0, 1'b0, 3'b000});
        vecs.push_back('{0, 479, 1'b1, 1'b1, 3'b110});
        vecs.push_back('{639, 479, 1'b1, 1'b1, 3'b010});
        vecs.push_back('{0, 480, 1'b1, 1'b1, 3'b000});
        vecs.push_back('{639, 480, 1'b1, 1'b1, 3'b000});
        vecs.push_back('{100, 300, 1'b1, 1'b0, 3'b000});
        for (int i = 0; i <= vecs.size(); i++) begin
            if (i < vecs.size()) begin
                cx = 10'(vecs[i].x); cy = 10'(vecs[i].y);
                hs_in = vecs[i].h; vs_in = vecs[i].v;
            end else begin
                cx = 10'd700; cy = 10'd0; hs_in = 1'b1; vs_in = 1'b0;
            end
            tick;
            if (i >= 1) begin
                check("vec_rgb", 32'(rgb), 32'(vecs[i-1].exp_rgb));
                check("vec_hs", 32'(hs), 32'(vecs[i-1].h));
                check("vec_vs", 32'(vs), 32'(vecs[i-1].v));
            end
        end

        // Random traffic against the cell model
        prev_rgb = 3'b000; prev_hs = 1'b1; prev_vs = 1'b0;
        for (int i = 0; i < 400; i++) begin
            int x, y, wa, ra;
            logic h, v, we, re;
            logic [2:0] wd, cur_rgb;
            x  = int'($urandom_range(1, 799));
            y  = int'($urandom_range(0, 524));
            h  = 1'($urandom_range(0, 1));
            v  = 1'($urandom_range(0, 1));
            we = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 0) wa = (y / 8) * 80 + x / 8;
            else wa = int'($urandom_range(0, 4900));
            wd = 3'($urandom_range(0, 7));
            re = ($urandom_range(0, 1) == 1);
            ra = ($urandom_range(0, 1) == 0) ? wa : int'($urandom_range(0, 4900));
            cx = 10'(x); cy = 10'(y); hs_in = h; vs_in = v;
            bus.wr_en = we; bus.wr_addr = 13'(wa); bus.wr_data = wd;
            bus.rd_en = re; bus.rd_addr = 13'(ra);
            cur_rgb = ref_pixel(x, y);
            if (re) last_rd = ref_read(ra);
            if (we && wa < NCELLS) model[wa] = wd;
            tick;
            check("rnd_rd", 32'(bus.rd_data), 32'(last_rd));
            check("rnd_vblank", 32'(vblank), 32'(y >= 480));
            check("rnd_fstart", 32'(frame_start), 32'd0);
            if (i > 0) begin
                check("rnd_rgb", 32'(rgb), 32'(prev_rgb));
                check("rnd_hs", 32'(hs), 32'(prev_hs));
                check("rnd_vs", 32'(vs), 32'(prev_vs));
            end
            prev_rgb = cur_rgb; prev_hs = h; prev_vs = v;
        end
        idle_bus;
        cx = 10'd700; cy = 10'd0; hs_in = 1'b1; vs_in = 1'b0;

        // Reset in the middle of a clear leaves the unswept cells intact
        cpu_write(0, 3'b111);
        cpu_write(NCELLS - 1, 3'b101);
        bus.clear_req = 1'b1;
        tick;
        bus.clear_req = 1'b0;
        repeat (20) tick;
        check("busy_mid_clear", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        tick;
        check("busy_after_reset", 32'(bus.busy), 32'd0);
        check("rd_after_reset", 32'(bus.rd_data), 32'd0);
        check("fcnt_after_reset", 32'(frame_cnt), 32'd0);
        reset = 1'b0;
        tick;
        check("busy_stays_idle", 32'(bus.busy), 32'd0);
        model[0] = 3'b000;
        cpu_read_check("swept_cell", 0);
        cpu_read_check("unswept_cell", NCELLS - 1);

        // Three sparse frames, first one parked at (0,0) for several cycles
        prev_zero = 1'b0; exp_cnt = 0; pulses = 0;
        for (int f = 0; f < 3; f++) begin
            for (int y = 0; y <= 525; y++) begin
                for (int k = 0; k < 2; k++) begin
                    int x, reps;
                    logic z;
                    x = (k == 0) ? 0 : 800;
                    reps = (f == 0 && y == 0 && k == 0) ? 3 : 1;
                    for (int r = 0; r < reps; r++) begin
                        cx = 10'(x); cy = 10'(y);
                        z = (x == 0 && y == 0);
                        if (z && !prev_zero) exp_cnt = (exp_cnt + 1) % 65536;
                        tick;
                        check("frm_fstart", 32'(frame_start), 32'(z && !prev_zero));
                        check("frm_vblank", 32'(vblank), 32'(y >= 480));
                        check("frm_cnt", 32'(frame_cnt), 32'(exp_cnt));
                        if (frame_start === 1'b1) pulses++;
                        prev_zero = z;
                    end
                end
            end
        end
        check("frame_pulses", 32'(pulses), 32'd3);
        check("frame_cnt_final", 32'(frame_cnt), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_fb_scanout.md
Name: vga_fb_scanout

Overview:
- Cell-based colour framebuffer between the CPU data bus and the VGA pins.
- The CPU writes 3-bit colours into an 80x60 grid of 8x8-pixel cells. The block reads the grid using the raster coordinates from the VGA timing counters.
- Outputs are registered rgb plus hs/vs delayed to the same latency. Also provides a frame counter, a vblank status and a hardware clear sequencer.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- CELL_SHIFT, 3, log2 of cell edge in pixels (8x8 cells).
- COLS, 80, cells per row (H_ACTIVE >> CELL_SHIFT).
- ROWS, 60, cell rows (V_ACTIVE >> CELL_SHIFT).
- AW, 13, cell address width (COLS*ROWS = 4800 <= 2^AW).

Ports:
- clk  in  1  pixel/CPU clock.
- reset  in  1  synchronous, active-high.
- cx  in  10  horizontal counter from timing (0..800).
- cy  in  10  vertical counter from timing (0..525).
- hs_in  in  1  hsync, active-low, aligned to cx/cy.
- vs_in  in  1  vsync, active-high, aligned to cx/cy.
- wr_en  in  1  CPU cell write strobe.
- wr_addr  in  AW  cell index, row*COLS+col.
- wr_data  in  3  colour {r,g,b}.
- rd_en  in  1  CPU cell read strobe.
- rd_addr  in  AW  cell index to read.
- rd_data  out  3  read result, valid 1 cycle after rd_en.
- clear_req  in  1  pulse: start hardware clear of all cells.
- busy  out  1  clear in progress.
- rgb  out  3  pixel colour, 0 outside the active area.
- hs  out  1  hs_in delayed 2 cycles.
- vs  out  1  vs_in delayed 2 cycles.
- vblank  out  1  registered (cy >= V_ACTIVE).
- frame_start  out  1  one-cycle pulse per frame.
- frame_cnt  out  16  frames since reset.

Behaviour:
- Reset values: rgb=0, hs=1, vs=0, vblank=0, frame_start=0, frame_cnt=0, busy=0, rd_data=0, FSM=IDLE. RAM contents are not reset.
- Scan pipeline, stage 1 (cycle N): register cell = (cy>>CELL_SHIFT)*COLS + (cx>>CELL_SHIFT), active = (cx<H_ACTIVE && cy<V_ACTIVE), hs_in and vs_in.
- Scan pipeline, stage 2 (cycle N+1): RAM read of cell; rgb <= active_d ? ram_q : 0.
- Scan latency: total 2 cycles from cx/cy to rgb. hs and vs use identical 2-stage delays, so pixel and sync stay aligned.
- The multiply by COLS is constant (80 = 64+16); use shift-add, no generic multiplier.
- RAM: one write port and two read ports (scan, CPU), all read-first. A read of an address written in the same cycle returns the old value.
- CPU write: accepted only when busy=0 and wr_addr < COLS*ROWS; otherwise silently dropped.
- CPU read: rd_data <= RAM[rd_addr] one cycle after rd_en. An out-of-range address returns 0. rd_data holds its value when rd_en=0. Reads work during a clear.
- Clear FSM state IDLE: clear_req=1 -> CLEAR with ptr=0 and busy=1 on the next cycle.
- Clear FSM state CLEAR: each cycle write 0 to RAM[ptr] and increment ptr. When ptr==COLS*ROWS-1, write it, then go to IDLE with busy=0. A full clear takes exactly 4800 cycles of busy=1.
- clear_req received while in CLEAR is ignored (no restart).
- Write arbitration: the clear write has priority; CPU writes are dropped while busy=1.
- Reset mid-clear: FSM returns to IDLE and busy=0; cells not yet cleared keep their old data.
- Frame tracking: frame_start=1 for one cycle when the registered stage-1 (cx,cy)==(0,0), and frame_cnt increments in the same cycle. frame_cnt wraps 0xFFFF->0.
- If the timing counter holds (0,0) for several cycles, frame_start pulses only on the first of them (edge-detected).
- vblank = registered (cy >= V_ACTIVE), 1-cycle latency. It is decoded from cy alone, independent of vs_in.

Decomposition:
- Shared package vga_pkg: H_ACTIVE, V_ACTIVE, H_TOTAL=800, V_TOTAL=525, CELL_SHIFT, COLS, ROWS, NCELLS=4800, clear FSM state encoding (IDLE=0, CLEAR=1).
- Sub-module vga_fb_ram: NCELLS x 3-bit RAM, one write port, two registered read-first read ports. This keeps RAM inference clean for the FPGA flow.

Test Plan:
- Reset: hold reset 3 cycles with cx/cy running -> rgb=0, hs=1, vs=0, frame_cnt=0, busy=0 throughout.
- Write wr_addr=81, wr_data=3'b101; scan (cx,cy)=(8..15, 8..15) -> rgb=3'b101 exactly 2 cycles after each coordinate. Neighbour cx=16 gives 0 (cell 82 unwritten/cleared).
- Blanking: write cell 0 = 3'b111; drive cx=640,cy=0 -> rgb=0. Drive hs_in low at cx=656 -> hs low 2 cycles later.
- Same-cycle conflict: rd_en and wr_en both at addr 5 (old 3'b010, new 3'b001) -> rd_data=3'b010; next read -> 3'b001. Write to addr 4800 -> dropped, read returns 0.
- Clear: fill cells with 3'b111, pulse clear_req -> busy=1 for 4800 cycles, then every cell reads 0. A CPU write during busy is dropped; a second clear_req mid-clear does not extend busy.
- Frames: run 3 full 801x526 frames -> 3 frame_start pulses, frame_cnt=3. vblank=1 for cy 480..525. Reset asserted mid-clear -> busy=0 next cycle.
